// File: rtl/sseg_scan_if.sv
// Pin and result bundle for the seven-segment scan decoder: scanned an/sseg pins in, captured digits out.
// There is no flow control; the decoder samples the pins on every clock edge.
interface sseg_scan_if;
   logic [3:0] an;
   logic [6:0] sseg;
   logic [6:0] out0, out1, out2, out3;
   logic [3:0] hex0, hex1, hex2, hex3;
   logic [3:0] hex_ok;
   logic       frame_valid;
   logic       an_err;

   modport master (
      output an, sseg,
      input  out0, out1, out2, out3, hex0, hex1, hex2, hex3, hex_ok, frame_valid, an_err
   );

   modport slave (
      input  an, sseg,
      output out0, out1, out2, out3, hex0, hex1, hex2, hex3, hex_ok, frame_valid, an_err
   );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Captures each digit of a multiplexed 7-seg display once its pins have been stable for SETTLE_CYCLES edges.
// Latency: outputs update SETTLE_CYCLES edges after the pins change. There is no backpressure.
module sseg_scan_decoder #(
   parameter int SETTLE_CYCLES = 4
) (
   input logic        clk,
   input logic        reset,
   sseg_scan_if.slave bus
);
   localparam logic [7:0] ACT_CNT = 8'(SETTLE_CYCLES - 1);

   logic [3:0] r_s_an;
   logic [6:0] r_s_sseg;
   logic [7:0] r_cnt;
   logic       r_armed;
   logic [6:0] r_out [4];
   logic [3:0] r_hex [4];
   logic [3:0] r_hex_ok;
   logic [3:0] r_seen;
   logic       r_frame_valid;
   logic       r_an_err;

   logic       w_changed;
   logic       w_act;
   logic       w_digit;
   logic [1:0] w_idx;
   logic [4:0] w_glyph;
   logic [3:0] w_seen_next;

   // Returns {matched, hex value}; unknown patterns decode to {0, 0}.
   function automatic logic [4:0] glyph_decode(input logic [6:0] p);
      case (p)
         7'b1000000: return 5'h10;
         7'b1111001: return 5'h11;
         7'b0100100: return 5'h12;
         7'b0110000: return 5'h13;
         7'b0011001: return 5'h14;
         7'b0010010: return 5'h15;
         7'b0000010: return 5'h16;
         7'b1111000: return 5'h17;
         7'b0000000: return 5'h18;
         7'b0010000: return 5'h19;
         7'b0001000: return 5'h1A;
         7'b0000011: return 5'h1B;
         7'b1000110: return 5'h1C;
         7'b0100001: return 5'h1D;
         7'b0000110: return 5'h1E;
         7'b0001110: return 5'h1F;
         default:    return 5'h00;
      endcase
   endfunction

   always_comb begin
      w_digit = 1'b1;
      w_idx   = 2'd0;
      case (r_s_an)
         4'b1110: w_idx = 2'd0;
         4'b1101: w_idx = 2'd1;
         4'b1011: w_idx = 2'd2;
         4'b0111: w_idx = 2'd3;
         default: w_digit = 1'b0;
      endcase
   end

   assign w_changed   = {bus.an, bus.sseg} != {r_s_an, r_s_sseg};
   assign w_act       = r_armed && (r_cnt == ACT_CNT);
   assign w_glyph     = glyph_decode(r_s_sseg);
   assign w_seen_next = r_seen | (4'b0001 << w_idx);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s_an        <= 4'hF;
         r_s_sseg      <= 7'h7F;
         r_cnt         <= 8'd0;
         r_armed       <= 1'b1;
         r_hex_ok      <= 4'h0;
         r_seen        <= 4'h0;
         r_frame_valid <= 1'b0;
         r_an_err      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_out[i] <= 7'h7F;
            r_hex[i] <= 4'h0;
         end
      end else begin
         r_s_an        <= bus.an;
         r_s_sseg      <= bus.sseg;
         r_frame_valid <= 1'b0;
         r_an_err      <= 1'b0;

         if (w_changed) begin
            r_cnt <= 8'd0;
         end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
         end

         // A fresh pattern re-arms even on the edge that consumes the previous one.
         if (w_changed) begin
            r_armed <= 1'b1;
         end else if (w_act) begin
            r_armed <= 1'b0;
         end

         if (w_act) begin
            if (w_digit) begin
               r_out[w_idx]    <= r_s_sseg;
               r_hex[w_idx]    <= w_glyph[3:0];
               r_hex_ok[w_idx] <= w_glyph[4];
               if (w_seen_next == 4'hF) begin
                  r_frame_valid <= 1'b1;
                  r_seen        <= 4'h0;
               end else begin
                  r_seen <= w_seen_next;
               end
            end else if (r_s_an != 4'hF) begin
               r_an_err <= 1'b1;
            end
         end
      end
   end

   assign bus.out0        = r_out[0];
   assign bus.out1        = r_out[1];
   assign bus.out2        = r_out[2];
   assign bus.out3        = r_out[3];
   assign bus.hex0        = r_hex[0];
   assign bus.hex1        = r_hex[1];
   assign bus.hex2        = r_hex[2];
   assign bus.hex3        = r_hex[3];
   assign bus.hex_ok      = r_hex_ok;
   assign bus.frame_valid = r_frame_valid;
   assign bus.an_err      = r_an_err;
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: directed scenarios plus random scans against a run-length reference model.
module tb_sseg_scan_decoder;
   localparam int SETTLE = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;

   sseg_scan_if bus();

   sseg_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0]  glyph [16];
   logic [6:0]  m_out [4];
   logic [3:0]  m_hex [4];
   logic [3:0]  m_ok;
   logic [3:0]  m_seen;
   logic        m_fv;
   logic        m_err;
   logic [10:0] run_pat;
   int          run_len;

   int          fv_cnt;
   int          err_cnt;
   logic [6:0]  fv_out3;
   logic [3:0]  fv_hex3;

   function automatic logic [49:0] pack(
      input logic [6:0] o0, input logic [6:0] o1, input logic [6:0] o2, input logic [6:0] o3,
      input logic [3:0] h0, input logic [3:0] h1, input logic [3:0] h2, input logic [3:0] h3,
      input logic [3:0] ok, input logic fv, input logic err);
      return {o0, o1, o2, o3, h0, h1, h2, h3, ok, fv, err};
   endfunction

   function automatic logic [49:0] dut_vec();
      return pack(bus.out0, bus.out1, bus.out2, bus.out3, bus.hex0, bus.hex1, bus.hex2, bus.hex3,
                  bus.hex_ok, bus.frame_valid, bus.an_err);
   endfunction

   function automatic logic [49:0] mdl_vec();
      return pack(m_out[0], m_out[1], m_out[2], m_out[3], m_hex[0], m_hex[1], m_hex[2], m_hex[3],
                  m_ok, m_fv, m_err);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // A pattern is acted on at the edge after its run of identical samples reaches SETTLE.
   task automatic model_edge(input logic [3:0] a, input logic [6:0] s, input logic rst);
      logic        fire;
      logic [10:0] act;
      logic [3:0]  oh;
      int          k;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_out[i] = 7'h7F;
            m_hex[i] = 4'h0;
         end
         m_ok    = 4'h0;
         m_seen  = 4'h0;
         m_fv    = 1'b0;
         m_err   = 1'b0;
         run_pat = {4'hF, 7'h7F};
         run_len = 1;
         return;
      end
      fire = (run_len == SETTLE);
      act  = run_pat;
      if ({a, s} == run_pat) begin
         run_len++;
      end else begin
         run_pat = {a, s};
         run_len = 1;
      end
      m_fv  = 1'b0;
      m_err = 1'b0;
      if (fire) begin
         k = -1;
         for (int i = 0; i < 4; i++) begin
            oh = 4'b0001 << i;
            if (act[10:7] == ~oh) k = i;
         end
         if (k >= 0) begin
            m_out[k] = act[6:0];
            m_hex[k] = 4'h0;
            m_ok[k]  = 1'b0;
            for (int g = 0; g < 16; g++) begin
               if (glyph[g] == act[6:0]) begin
                  m_hex[k] = 4'(g);
                  m_ok[k]  = 1'b1;
               end
            end
            m_seen[k] = 1'b1;
            if (m_seen == 4'hF) begin
               m_fv   = 1'b1;
               m_seen = 4'h0;
            end
         end else if (act[10:7] != 4'hF) begin
            m_err = 1'b1;
         end
      end
   endtask

   task automatic step(input logic [3:0] a, input logic [6:0] s, input int n);
      for (int c = 0; c < n; c++) begin
         bus.an   = a;
         bus.sseg = s;
         @(posedge clk);
         model_edge(a, s, reset);
         #1;
         check("cycle", 64'(dut_vec()), 64'(mdl_vec()));
         if (bus.frame_valid === 1'b1) begin
            fv_cnt++;
            fv_out3 = bus.out3;
            fv_hex3 = bus.hex3;
         end
         if (bus.an_err === 1'b1) err_cnt++;
      end
   endtask

   logic [49:0] exp_v;
   logic [3:0]  r_a;
   logic [6:0]  r_s;
   logic [3:0]  oh_r;

   initial begin
      glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
      glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
      glyph[8]  = 7'b0000000; glyph[9]  = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
      glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
      fv_cnt  = 0;
      err_cnt = 0;
      fv_out3 = 7'h00;
      fv_hex3 = 4'h0;

      reset = 1'b1;
      step(4'b1110, 7'b0100100, 2);
      check("reset_state", 64'(dut_vec()),
            64'(pack(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0)));
      reset = 1'b0;

      // Single digit latency and no re-capture while held.
      step(4'b1110, 7'b0100100, 4);
      check("settle_early_out0", 64'(bus.out0), 64'(7'h7F));
      step(4'b1110, 7'b0100100, 1);
      exp_v = pack(7'b0100100, 7'h7F, 7'h7F, 7'h7F, 4'h2, 4'h0, 4'h0, 4'h0, 4'b0001, 1'b0, 1'b0);
      check("settle_capture", 64'(dut_vec()), 64'(exp_v));
      step(4'b1110, 7'b0100100, 20);
      check("held_no_change", 64'(dut_vec()), 64'(exp_v));

      // Full scan of 1,2,3,4.
      fv_cnt = 0;
      step(4'b1110, 7'b1111001, 8);
      step(4'b1101, 7'b0100100, 8);
      step(4'b1011, 7'b0110000, 8);
      step(4'b0111, 7'b0011001, 8);
      check("frame_pulse_count", 64'(fv_cnt), 64'd1);
      check("frame_out3", 64'(fv_out3), 64'(7'b0011001));
      check("frame_hex3", 64'(fv_hex3), 64'h4);
      exp_v = pack(7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF, 1'b0, 1'b0);
      check("frame_outputs", 64'(dut_vec()), 64'(exp_v));

      // Short glitch and illegal anode pattern.
      err_cnt = 0;
      step(4'b1101, 7'b1000000, 3);
      step(4'b1111, 7'h7F, 8);
      check("glitch_no_change", 64'(dut_vec()), 64'(exp_v));
      step(4'b1001, 7'b1000000, 4);
      step(4'b1111, 7'h7F, 6);
      check("an_err_count", 64'(err_cnt), 64'd1);
      check("an_err_no_change", 64'(dut_vec()), 64'(exp_v));

      // Unknown pattern still loads and counts toward the frame.
      fv_cnt = 0;
      step(4'b1101, 7'h7F, 6);
      check("unknown_out1", 64'(bus.out1), 64'(7'h7F));
      check("unknown_hex1", 64'(bus.hex1), 64'h0);
      check("unknown_ok", 64'(bus.hex_ok), 64'(4'b1101));
      step(4'b1110, 7'b1000000, 6);
      step(4'b1011, 7'b0010000, 6);
      check("partial_no_frame", 64'(fv_cnt), 64'd0);
      step(4'b0111, 7'b0001000, 6);
      check("unknown_frame_count", 64'(fv_cnt), 64'd1);

      // Reset mid-frame discards partial progress.
      fv_cnt = 0;
      step(4'b1110, 7'b0010010, 6);
      step(4'b1101, 7'b0000010, 6);
      step(4'b1011, 7'b1111000, 6);
      reset = 1'b1;
      step(4'b1011, 7'b1111000, 1);
      reset = 1'b0;
      step(4'b0111, 7'b0000000, 8);
      check("reset_frame_count", 64'(fv_cnt), 64'd0);
      check("reset_partial", 64'(dut_vec()),
            64'(pack(7'h7F, 7'h7F, 7'h7F, 7'b0000000, 4'h0, 4'h0, 4'h0, 4'h8, 4'b1000, 1'b0, 1'b0)));

      // Random scanning, glitches, illegal anodes and occasional resets.
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1;
            step(4'b1111, 7'h7F, 1);
            reset = 1'b0;
         end
         case ($urandom_range(0, 5))
            0, 1, 2: begin
               oh_r = 4'b0001 << $urandom_range(0, 3);
               r_a  = ~oh_r;
               r_s  = glyph[$urandom_range(0, 15)];
            end
            3: begin
               oh_r = 4'b0001 << $urandom_range(0, 3);
               r_a  = ~oh_r;
               r_s  = 7'($urandom);
            end
            4: begin
               r_a = 4'hF;
               r_s = 7'($urandom);
            end
            default: begin
               r_a = 4'($urandom);
               r_s = 7'($urandom);
            end
         endcase
         step(r_a, r_s, $urandom_range(1, 8));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sseg_scan_decoder.md
SSEG_SCAN_DECODER -- requirements
Module: sseg_scan_decoder

Interface
REQ-001 Parameter: SETTLE_CYCLES, default 4, sampling edges a pin pattern must be held before capture (legal range 2..255).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 an  input  4  anode enables, active-low; scan order 1110, 1101, 1011, 0111 selects digit 0..3.
REQ-005 sseg  input  7  segment lines, active-low; sseg[0]=a ... sseg[6]=g.
REQ-006 out0, out1, out2, out3  output  7 each  raw segment pattern last captured for digit 0..3.
REQ-007 hex0, hex1, hex2, hex3  output  4 each  hex value decoded from out0..out3.
REQ-008 hex_ok  output  4  bit k=1 when the last capture for digit k matched a hex glyph.
REQ-009 frame_valid  output  1  one-cycle pulse when all four digits have been captured since the last pulse.
REQ-010 an_err  output  1  one-cycle pulse when an illegal anode pattern is captured.

Function
REQ-011 Sampler: each edge, s_an/s_sseg SHALL load the pins, and the 8-bit saturating counter cnt SHALL go to 0 if the pins differ from {s_an,s_sseg}, else increment.
REQ-012 Armed flag SHALL set on any edge where cnt loads 0 and SHALL clear on the edge that acts on a stable pattern.
REQ-013 Act condition: armed=1 and cnt==SETTLE_CYCLES-1, evaluated on the registered values; the action SHALL take effect at the next edge using {s_an,s_sseg}.
REQ-014 Latency: pins changed before sampling edge 0 and held through edge SETTLE_CYCLES-1 SHALL update outputs at edge SETTLE_CYCLES.
REQ-015 Exactly one action per stable interval; a pattern held indefinitely SHALL NOT be re-captured.
REQ-016 Patterns shorter than SETTLE_CYCLES edges (ghosting or glitches) SHALL cause no output change.
REQ-017 Action for s_an one-hot-low (digit k): load out_k with s_sseg, load hex_k and hex_ok[k] from the glyph table, and set seen-mask bit k.
REQ-018 Action for s_an=1111 (blank): no output change, no error.
REQ-019 Action for any other s_an pattern: pulse an_err for one cycle; outputs and seen mask unchanged.
REQ-020 Glyph table (hex: sseg[6:0]): 0:1000000 1:1111001 2:0100100 3:0110000 4:0011001 5:0010010 6:0000010 7:1111000.
REQ-021 Glyph table, continued: 8:0000000 9:0010000 A:0001000 b:0000011 C:1000110 d:0100001 E:0000110 F:0001110.
REQ-022 A pattern not in the table SHALL give hex_k=0 and hex_ok[k]=0; out_k SHALL still load.
REQ-023 A capture that makes the seen mask 1111 SHALL pulse frame_valid on that same edge and clear the mask to 0000 on that edge.
REQ-024 Re-capture of an already-seen digit before the frame completes SHALL overwrite out_k/hex_k/hex_ok[k]; the mask is unchanged.
REQ-025 Capture order SHALL NOT matter; any order covering all four digits completes a frame.
REQ-026 Outside the defined pulse edges, frame_valid and an_err SHALL be 0.

Reset
REQ-027 While reset=1 at an edge: out0..out3=7'h7F, hex0..hex3=0, hex_ok=0, frame_valid=0, an_err=0, seen mask=0, s_an=4'hF, s_sseg=7'h7F, cnt=0, armed=1.
REQ-028 Reset asserted mid-capture or mid-frame SHALL discard all partial progress; after release, the first action requires a full SETTLE_CYCLES hold.

Verification
REQ-029 SETTLE_CYCLES=4; drive an=1110, sseg=0100100 from edge 0 -> out0=0100100, hex0=2, hex_ok[0]=1 after edge 4, and no further change while held.
REQ-030 Scan digits 0..3 with glyphs 1,2,3,4, each held 8 cycles -> frame_valid high for exactly one cycle, coincident with out3=0011001, hex3=4; mask returns to 0000.
REQ-031 Hold an=1101 for 3 edges, then change (SETTLE_CYCLES=4) -> no output change; hold an=1001 for 4 edges -> an_err pulses once, outputs unchanged.
REQ-032 Drive digit 1 with 1111111 -> out1=1111111, hex1=0, hex_ok[1]=0, and the digit still counts toward the frame.
REQ-033 Capture digits 0 to 2, then assert reset for 1 cycle, then capture digit 3 only -> no frame_valid, all outputs except out3/hex3/hex_ok[3] at their reset values.
